// File: rtl/chase_pkg.sv
// rtl/chase_pkg.sv - shared mode and direction encodings for the LED chaser
package chase_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FWD      = 2'd0;
    localparam mode_t MODE_REV      = 2'd1;
    localparam mode_t MODE_PINGPONG = 2'd2;
    localparam mode_t MODE_BLINK    = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/chase_tick_gen.sv
// rtl/chase_tick_gen.sv - enable-gated prescaler producing one tick every delay+1 cycles
module chase_tick_gen #(
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DELAY_W-1:0] delay,
    input  logic               restart,
    output logic               tick
);

    logic [DELAY_W-1:0] cnt_q;
    logic [DELAY_W-1:0] cnt_d;

    // >= rather than == so a shrinking delay can never strand the counter
    assign tick = enable && (cnt_q >= delay);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chase_sequencer.sv
// rtl/chase_sequencer.sv - LED chase controller with mode/speed command port applied at step boundaries
module chase_sequencer
    import chase_pkg::*;
#(
    parameter int NUM_LEDS      = 6,
    parameter int DELAY_W       = 8,
    parameter int DEFAULT_DELAY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [DELAY_W-1:0]  cmd_delay,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_pulse,
    output logic [1:0]          cur_mode
);

    localparam int            PW   = $clog2(NUM_LEDS);
    localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);

    logic               pend_full_q, pend_full_d;
    mode_t              pend_mode_q, pend_mode_d;
    logic [DELAY_W-1:0] pend_delay_q, pend_delay_d;
    mode_t              mode_q, mode_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               phase_q, phase_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic               step_q, step_d;
    logic               tick;
    logic               accept;
    logic               apply;

    assign accept = cmd_valid && !pend_full_q;
    // Freezing the timebase counts as a boundary so commands still land while paused
    assign apply  = pend_full_q && (tick || !enable);

    chase_tick_gen #(
        .DELAY_W (DELAY_W)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .delay   (delay_q),
        .restart (apply),
        .tick    (tick)
    );

    always_comb begin
        pend_full_d  = pend_full_q;
        pend_mode_d  = pend_mode_q;
        pend_delay_d = pend_delay_q;
        mode_d       = mode_q;
        delay_d      = delay_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        phase_d      = phase_q;
        step_d       = 1'b0;

        if (accept) begin
            pend_full_d  = 1'b1;
            pend_mode_d  = cmd_mode;
            pend_delay_d = cmd_delay;
        end

        if (apply) begin
            pend_full_d = 1'b0;
            mode_d      = pend_mode_q;
            delay_d     = pend_delay_q;
            dir_d       = DIR_UP;
            phase_d     = 1'b0;
            pos_d       = (pend_mode_q == MODE_REV) ? LAST : '0;
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_FWD: pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                MODE_REV: pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
                MODE_PINGPONG: begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q == LAST) begin
                            dir_d = DIR_DOWN;
                            pos_d = pos_q - 1'b1;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = DIR_UP;
                            pos_d = pos_q + 1'b1;
                        end else begin
                            pos_d = pos_q - 1'b1;
                        end
                    end
                end
                default: phase_d = !phase_q;
            endcase
        end

        if (mode_d == MODE_BLINK) begin
            led_d = {NUM_LEDS{phase_d}};
        end else begin
            led_d = NUM_LEDS'(1) << pos_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_full_q  <= 1'b0;
            pend_mode_q  <= MODE_FWD;
            pend_delay_q <= '0;
            mode_q       <= MODE_FWD;
            delay_q      <= DELAY_W'(DEFAULT_DELAY);
            pos_q        <= '0;
            dir_q        <= DIR_UP;
            phase_q      <= 1'b0;
            led_q        <= NUM_LEDS'(1);
            step_q       <= 1'b0;
        end else begin
            pend_full_q  <= pend_full_d;
            pend_mode_q  <= pend_mode_d;
            pend_delay_q <= pend_delay_d;
            mode_q       <= mode_d;
            delay_q      <= delay_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
            led_q        <= led_d;
            step_q       <= step_d;
        end
    end

    assign cmd_ready  = !pend_full_q;
    assign led        = led_q;
    assign step_pulse = step_q;
    assign cur_mode   = mode_q;

endmodule

// File: doc/chase_sequencer.md
Name: chase_sequencer

Overview:
- Programmable controller for the LED chaser bank. Owns the step timebase, the scan position and direction, and the display mode.
- Accepts mode/speed reconfiguration over a valid/ready command port and applies it glitch-free at step boundaries.
- Sits between the board control logic (buttons/UART decoder) and the LED pins. Replaces the fixed forward-only chase.

Parameters:
- NUM_LEDS, 6, LEDs in the bank (≥2).
- DELAY_W, 8, width of the step-delay field.
- DEFAULT_DELAY, 3, delay value loaded at reset. Step period = delay+1 enabled cycles.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  advance timebase when high; freeze when low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command slot free
- cmd_mode  in  2  0=FWD, 1=REV, 2=PINGPONG, 3=BLINK
- cmd_delay  in  DELAY_W  new step delay
- led  out  NUM_LEDS  registered LED drive
- step_pulse  out  1  one-cycle strobe on every position/phase advance
- cur_mode  out  2  mode currently displayed

Behaviour:
- Reset values: mode=FWD, delay_r=DEFAULT_DELAY, cnt=0, pos=0, dir=up, blink phase=0, pending empty.
- Outputs at reset: cmd_ready=1, led=one-hot bit0, step_pulse=0, cur_mode=0.
- Reset has priority over everything. Reset mid-operation discards a pending command.
- Timebase: if enable and cnt>=delay_r, a step fires and cnt<=0. Else if enable, cnt<=cnt+1. If enable=0, cnt holds.
- delay_r=0 means a step fires every enabled cycle.
- Step actions by mode:
  - FWD: pos+1, wrapping N-1→0.
  - REV: pos-1, wrapping 0→N-1.
  - PINGPONG: move in dir. When at N-1 moving up, flip dir to down and go to N-2. When at 0 moving down, flip dir to up and go to 1. No dwell at the ends.
  - BLINK: phase toggles.
- led encoding:
  - FWD/REV/PINGPONG: one-hot (1<<pos).
  - BLINK: all ones when phase=1, all zeros when phase=0.
- led and step_pulse are registered. led shows the new pattern in the same cycle step_pulse is high, i.e. one cycle after the step condition.
- Command handshake:
  - Transfer occurs when cmd_valid&&cmd_ready. Fields are captured into a one-entry pending register.
  - cmd_ready=0 while pending is full.
  - Host must hold cmd_valid and fields stable until accepted.
- Apply rule: pending is applied on the first cycle where pending is full and either (a) a step would fire, or (b) enable=0.
- On apply:
  - mode and delay_r are loaded; cnt<=0; pending is cleared, so cmd_ready returns high next cycle.
  - Position is re-initialised: FWD/PINGPONG pos=0 with dir=up; REV pos=N-1; BLINK phase=0.
  - led takes the initial pattern of the new mode.
  - The step that would have fired is consumed by the apply: no advance, and step_pulse stays 0.
- Accept and apply never happen in the same cycle, because ready is low while pending is full. Minimum command-to-command spacing is 2 cycles.
- A command with the same mode and delay is still applied and still restarts the pattern.
- cmd_mode values are all legal. No error path.

Decomposition:
- Package chase_pkg:
  - mode encoding constants MODE_FWD/REV/PINGPONG/BLINK
  - mode typedef (2-bit)
  - dir encoding DIR_UP/DIR_DOWN
- Sub-module chase_tick_gen (parameter DELAY_W):
  - Inputs: clk, reset, enable, delay, restart (sync cnt clear).
  - Output: tick. Implements the prescaler counter.
- chase_sequencer instantiates one chase_tick_gen and holds the pending register, mode/pos/dir/phase registers and the LED encoder.

Test Plan:
1. Reset, enable=1, no commands → step_pulse every 4 cycles. led walks 000001→000010→…→100000→000001. First advance occurs 4 enabled cycles after reset release.
2. Command mode=PINGPONG, delay=0, enable=1 → cmd_ready drops for exactly one cycle and led restarts at 000001 with no step_pulse that cycle. Sequence then runs bit0,1,2,3,4,5,4,3,2,1,0,1 on consecutive cycles.
3. Command mode=REV, delay=1 → led=100000 on apply, then 010000, 001000, … every 2 cycles. After 000001 it wraps to 100000.
4. Command mode=BLINK, delay=2 → led=000000 on apply, then 111111, 000000 alternating every 3 cycles, with step_pulse coincident.
5. enable=0 for 10 cycles mid-chase at led=000100 → led and cnt frozen, no step_pulse. A command (FWD, delay=5) issued during freeze applies the next cycle (led=000001). After enable=1, the first step comes 6 cycles later.
6. Accept a command, then assert reset before the apply → pending discarded, all reset values restored, cmd_ready=1 the cycle after reset.
